bus_cycle_sequencer: RTL

- Arbitrates the shared memory address bus between the instruction-fetch requester and the data-access requester.
- Sequences each memory cycle through setup, strobe and wait states.
- Drives the 2-bit address-source select consumed by the address bus multiplexer.
- Sits between the CPU control unit and the external memory interface.

---
 rtl/bus_cycle_sequencer_pkg.sv | 32 +++
 rtl/bus_cycle_sequencer_wait_counter.sv | 74 +++++++
 rtl/bus_cycle_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_sequencer_pkg.sv
// bus_cycle_sequencer_pkg
//   Shared encodings for the memory bus cycle sequencer:
//   - address-source select values driven on ADDR_BUSX
//   - sequencer state encodings
//   - requester grant codes
//   - counter widths used by the wait/watchdog counter
package bus_cycle_sequencer_pkg;

    typedef enum logic [1:0] {
        SRC_PC       = 2'd0,
        SRC_ALU_R    = 2'd1,
        SRC_REG_B    = 2'd2,
        SRC_ALUA_DIN = 2'd3
    } addr_src_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } grant_e;

    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned WD_CNT_W   = 8;

endpackage

// File: rtl/bus_cycle_sequencer_wait_counter.sv
// bus_wait_counter
//   Loadable down-counter with zero flag that paces the strobe phase, plus an
//   optional strobe-phase watchdog (enabled by macro BUS_SEQ_TIMEOUT_EN).
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   load       load load_val into the counter and clear the watchdog (SETUP)
//   load_val   wait-state count
//   strobe     high while the sequencer is in STROBE
//   cnt_zero   counter has reached zero
//   wd_timeout watchdog has counted TIMEOUT_CYCLES strobe cycles (0 without macro)
module bus_wait_counter
    import bus_cycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  strobe,
    output logic                  cnt_zero,
    output logic                  wd_timeout
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (strobe && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);

`ifdef BUS_SEQ_TIMEOUT_EN
    logic [WD_CNT_W-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (load) begin
            wd_d = '0;
        end else if (strobe && (wd_q != '1)) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // wd_q holds the number of strobe cycles already completed, so the
    // current strobe cycle is the TIMEOUT_CYCLES-th one when wd_q == limit-1.
    assign wd_timeout = strobe && (wd_q == WD_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_timeout = 1'b0;
`endif

endmodule

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer
//   Arbitrates the shared memory address bus between instruction fetch and
//   data access (data has fixed priority) and sequences each memory cycle
//   IDLE -> SETUP -> STROBE -> DONE -> IDLE. All outputs are registered from
//   the current state, so they appear one edge after the state is entered.
//   Optional strobe-phase watchdog: define BUS_SEQ_TIMEOUT_EN.
// Ports:
//   CLK, RESET       clock, synchronous active-high reset
//   FETCH_REQ/ACK    fetch request (source PC, read) / completion pulse
//   DATA_REQ/ACK     data request / completion pulse
//   DATA_WE          1 = write, latched at grant
//   DATA_SRC         data address source, latched at grant
//   MEM_RDY          memory ready, extends the strobe while low
//   ADDR_BUSX        address-source select
//   MEM_CE/RD/WR     chip enable, read strobe, write strobe
//   BUSY             sequencer not idle
//   BUS_ERR          watchdog timeout pulse (0 without the macro)
module bus_cycle_sequencer
    import bus_cycle_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_STATES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FETCH_REQ,
    output logic       FETCH_ACK,
    input  logic       DATA_REQ,
    input  logic       DATA_WE,
    input  logic [1:0] DATA_SRC,
    output logic       DATA_ACK,
    input  logic       MEM_RDY,
    output logic [1:0] ADDR_BUSX,
    output logic       MEM_CE,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       BUSY,
    output logic       BUS_ERR
);

    seq_state_e state_q, state_d;
    grant_e     grant_q, grant_d;
    addr_src_e  src_q,   src_d;
    logic       we_q,    we_d;

    logic cnt_zero;
    logic wd_timeout;

`ifdef BUS_SEQ_TIMEOUT_EN
    logic err_q, err_d;
`endif

    bus_wait_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clk        (CLK),
        .reset      (RESET),
        .load       (state_q == ST_SETUP),
        .load_val   (WAIT_CNT_W'(WAIT_STATES)),
        .strobe     (state_q == ST_STROBE),
        .cnt_zero   (cnt_zero),
        .wd_timeout (wd_timeout)
    );

    // Next-state, arbitration and grant latch
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        src_d   = src_q;
        we_d    = we_q;
`ifdef BUS_SEQ_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (DATA_REQ) begin
                    grant_d = GNT_DATA;
                    src_d   = addr_src_e'(DATA_SRC);
                    we_d    = DATA_WE;
                    state_d = ST_SETUP;
                end else if (FETCH_REQ) begin
                    grant_d = GNT_FETCH;
                    src_d   = SRC_PC;
                    we_d    = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
`ifdef BUS_SEQ_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            ST_STROBE: begin
                if (cnt_zero && MEM_RDY) begin
                    state_d = ST_DONE;
                end else if (wd_timeout) begin
                    state_d = ST_DONE;
`ifdef BUS_SEQ_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state; registered below
    logic [1:0] addr_d;
    logic       ce_d, rd_d, wr_d, busy_d, fack_d, dack_d, berr_d;
    logic [1:0] addr_q;
    logic       ce_q, rd_q, wr_q, busy_q, fack_q, dack_q, berr_q;

    always_comb begin
        addr_d = SRC_PC;
        ce_d   = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        busy_d = 1'b0;
        fack_d = 1'b0;
        dack_d = 1'b0;
        berr_d = 1'b0;
        if (state_q != ST_IDLE) begin
            addr_d = src_q;
            ce_d   = 1'b1;
            busy_d = 1'b1;
        end
        if (state_q == ST_STROBE) begin
            rd_d = ~we_q;
            wr_d = we_q;
        end
        if (state_q == ST_DONE) begin
            fack_d = (grant_q == GNT_FETCH);
            dack_d = (grant_q == GNT_DATA);
`ifdef BUS_SEQ_TIMEOUT_EN
            berr_d = err_q;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
            src_q   <= SRC_PC;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ce_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            fack_q  <= 1'b0;
            dack_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            fack_q  <= fack_d;
            dack_q  <= dack_d;
            berr_q  <= berr_d;
        end
    end

`ifdef BUS_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign ADDR_BUSX = addr_q;
    assign MEM_CE    = ce_q;
    assign MEM_RD    = rd_q;
    assign MEM_WR    = wr_q;
    assign BUSY      = busy_q;
    assign FETCH_ACK = fack_q;
    assign DATA_ACK  = dack_q;
    assign BUS_ERR   = berr_q;

endmodule
